vbs_timing_gen: RTL
===================

# vbs_timing_gen

Parametrised composite video (VBS) timing generator: successor to the fixed 256-clock × 313-line sync generator. It produces the single-wire composite sync pattern, including equalising/vsync lines, for any line length, hsync width, frame height and vsync length. It adds raster coordinates, an active-window pixel request/return path and an optional end-of-frame interrupt. It sits between the pixel clock domain and the video DAC and feeds the video RAM fetch logic.

## Interface
- LINE_CLKS, 256, clocks per line (≥ HSYNC_CLKS+3)
- HSYNC_CLKS, 14, hsync pulse length in clocks
- FRAME_LINES, 313, lines per frame
- VSYNC_LINES, 4, vsync lines at frame start (≥ 2)
- ACT_X0, 64, first active clock in line (> HSYNC_CLKS)
- ACT_W, 128, active clocks per line (ACT_X0+ACT_W ≤ LINE_CLKS)
- ACT_Y0, 40, first active line (≥ VSYNC_LINES)
- ACT_H, 192, active lines (ACT_Y0+ACT_H < FRAME_LINES)
- clk  in  1  pixel clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sync  out  1  composite sync level
- h_pos  out  HW=$clog2(LINE_CLKS)  current clock within line
- v_pos  out  VW=$clog2(FRAME_LINES)  current line within frame
- pixel_req  out  1  high while (h_pos,v_pos) inside active window
- pixel_in  in  1  pixel bit returned for the request of the same cycle
- pixel  out  1  video pixel, 0 outside active window
- frame_irq  out  1  end-of-active-area interrupt (sticky)
- irq_ack  in  1  single-cycle acknowledge of frame_irq

## Operation
- h_pos counts 0..LINE_CLKS-1 and wraps to 0; on wrap v_pos increments, wrapping FRAME_LINES-1 → 0.
- Each line has three segments: edge (h=0), hsync (1..HSYNC_CLKS), tail (rest).
- Segment levels (hsync H, tail T) per line: v=0: H=0,T=0; v=1..VSYNC_LINES-2: H=1,T=0; v=VSYNC_LINES-1: H=1,T=1; all other lines: H=0,T=1.
- Edge cycle outputs the T level of the previous line (line 0 takes T of line FRAME_LINES-1, i.e. 1). Default parameters therefore reproduce the existing pattern exactly: line 0 = 1,0×255; lines 1–2 = 0,1×14,0×241; line 3 = 0,1×255; lines 4–312 = 1,0×14,1×241.
- pixel_req = (ACT_X0 ≤ h_pos < ACT_X0+ACT_W) && (ACT_Y0 ≤ v_pos < ACT_Y0+ACT_H).
- pixel_in is sampled on every cycle with pixel_req=1; pixel = sampled value one cycle later, else 0.
- frame_irq sets on the cycle where h_pos=0, v_pos=ACT_Y0+ACT_H; clears on irq_ack. Set and ack in the same cycle: set wins.

## Timing
- Reset values: h_pos=0, v_pos=0, sync=1, pixel_req=0, pixel=0, frame_irq=0.
- sync, h_pos, v_pos, pixel_req are registered and mutually aligned: the first cycle after reset release shows the line-0 edge (sync=1).
- pixel latency: 1 clock after pixel_req; no gaps or bubbles.
- frame_irq rises 1 clock after the trigger position is presented; it drops the clock after irq_ack.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous); counting restarts at the line-0 edge.
- Frame period: LINE_CLKS × FRAME_LINES clocks, with no extra cycles at wraps.

## Configuration
- VBS_FRAME_IRQ_EN defined: frame_irq logic as above.
- Not defined: frame_irq is constant 0, irq_ack is ignored, and no IRQ flop is synthesised; ports remain present.

## Structure
- Package vbs_pkg holds:
  - default timing constants (LINE_CLKS, HSYNC_CLKS, FRAME_LINES, VSYNC_LINES, window defaults)
  - segment encoding (EDGE/HSYNC/TAIL)
  - the line-level function returning {H,T} for a line number
- Sub-module vbs_raster_counter: h/v counters with wrap and line-end strobe. Sync decode, window compare and IRQ stay in the top module.

## Test plan
- Default parameters, 3 full frames after reset: sync matches the four line patterns above on every clock; period is 80128 clocks.
- LINE_CLKS=64, HSYNC_CLKS=4, FRAME_LINES=10, VSYNC_LINES=3: line 0 = 1,0×63; line 1 = 0,1×4,0×59; line 2 = 0,1×63; lines 3–9 = 1,0×4,1×59.
- pixel_in driven as h_pos[0]: pixel is 0 outside the window; inside, pixel equals the previous cycle's h_pos[0]. First active pixel appears at h_pos=65, v_pos=40.
- Trigger at v_pos=232, h_pos=0 (VBS_FRAME_IRQ_EN): frame_irq=1 one clock later, held for 100 clocks, then irq_ack → 0 next clock. Ack coincident with a new trigger → stays 1.
- reset_n pulsed low at h_pos=100, v_pos=150: outputs go to reset values without waiting for clk; after release the next frame starts at line 0 with sync=1.
- Build without VBS_FRAME_IRQ_EN: frame_irq stays 0 for a full frame while irq_ack toggles.

Source files
------------

// File: rtl/vbs_pkg.sv
// Shared timing defaults, segment encoding and per-line sync levels
// for the composite video timing generator.
package vbs_pkg;

    localparam int DEF_LINE_CLKS   = 256;
    localparam int DEF_HSYNC_CLKS  = 14;
    localparam int DEF_FRAME_LINES = 313;
    localparam int DEF_VSYNC_LINES = 4;
    localparam int DEF_ACT_X0      = 64;
    localparam int DEF_ACT_W       = 128;
    localparam int DEF_ACT_Y0      = 40;
    localparam int DEF_ACT_H       = 192;

    typedef enum logic [1:0] {
        SEG_EDGE,
        SEG_HSYNC,
        SEG_TAIL
    } seg_t;

    typedef struct packed {
        logic h;
        logic t;
    } lvl_t;

    // Tail level is low only on the first VSYNC_LINES-1 lines.
    function automatic logic line_tail(input int v, input int vsync_lines);
        return (v >= vsync_lines - 1);
    endfunction

    function automatic lvl_t line_lvl(input int v, input int vsync_lines);
        lvl_t l;
        l.h = (v >= 1) && (v <= vsync_lines - 1);
        l.t = line_tail(v, vsync_lines);
        return l;
    endfunction

endpackage

// File: rtl/vbs_raster_counter.sv
// Horizontal/vertical raster counters with wrap and line-end strobe.
// Exposes next-state values so downstream flops stay aligned with h/v.
module vbs_raster_counter #(
    parameter int LINE_CLKS   = 256,
    parameter int FRAME_LINES = 313,
    parameter int HW          = 8,
    parameter int VW          = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [HW-1:0] h_pos,
    output logic [VW-1:0] v_pos,
    output logic [HW-1:0] h_nxt,
    output logic [VW-1:0] v_nxt,
    output logic          line_end
);

    localparam logic [HW-1:0] HMAX = HW'(LINE_CLKS - 1);
    localparam logic [VW-1:0] VMAX = VW'(FRAME_LINES - 1);

    assign line_end = (h_pos == HMAX);

    always_comb begin
        h_nxt = line_end ? '0 : h_pos + 1'b1;
        v_nxt = v_pos;
        if (line_end) begin
            v_nxt = (v_pos == VMAX) ? '0 : v_pos + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_pos <= '0;
            v_pos <= '0;
        end else begin
            h_pos <= h_nxt;
            v_pos <= v_nxt;
        end
    end

endmodule

// File: rtl/vbs_timing_gen.sv
// Parametrised composite sync generator with raster coordinates and pixel path.
// Define VBS_FRAME_IRQ_EN to build the sticky end-of-active-area interrupt.
module vbs_timing_gen
    import vbs_pkg::*;
#(
    parameter int LINE_CLKS   = DEF_LINE_CLKS,
    parameter int HSYNC_CLKS  = DEF_HSYNC_CLKS,
    parameter int FRAME_LINES = DEF_FRAME_LINES,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int ACT_X0      = DEF_ACT_X0,
    parameter int ACT_W       = DEF_ACT_W,
    parameter int ACT_Y0      = DEF_ACT_Y0,
    parameter int ACT_H       = DEF_ACT_H,
    localparam int HW         = $clog2(LINE_CLKS),
    localparam int VW         = $clog2(FRAME_LINES)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          sync,
    output logic [HW-1:0] h_pos,
    output logic [VW-1:0] v_pos,
    output logic          pixel_req,
    input  logic          pixel_in,
    output logic          pixel,
    output logic          frame_irq,
    input  logic          irq_ack
);

    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          line_end;

    vbs_raster_counter #(
        .LINE_CLKS   (LINE_CLKS),
        .FRAME_LINES (FRAME_LINES),
        .HW          (HW),
        .VW          (VW)
    ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .h_pos    (h_pos),
        .v_pos    (v_pos),
        .h_nxt    (h_nxt),
        .v_nxt    (v_nxt),
        .line_end (line_end)
    );

    seg_t seg;
    lvl_t lvl_cur;
    logic prev_t;
    logic sync_d;
    logic req_d;
    int   hn;
    int   vn;
    int   vp;

    // Decode against next-state position so registered outputs line up.
    always_comb begin
        hn      = int'(h_nxt);
        vn      = int'(v_nxt);
        vp      = (vn == 0) ? FRAME_LINES - 1 : vn - 1;
        lvl_cur = line_lvl(vn, VSYNC_LINES);
        prev_t  = line_tail(vp, VSYNC_LINES);
        seg     = SEG_TAIL;
        unique case (1'b1)
            (hn == 0):                       seg = SEG_EDGE;
            (hn >= 1 && hn <= HSYNC_CLKS):   seg = SEG_HSYNC;
            (hn > HSYNC_CLKS):               seg = SEG_TAIL;
        endcase
        unique case (seg)
            SEG_EDGE:  sync_d = prev_t;
            SEG_HSYNC: sync_d = lvl_cur.h;
            default:   sync_d = lvl_cur.t;
        endcase
        req_d = (hn >= ACT_X0) && (hn < ACT_X0 + ACT_W) &&
                (vn >= ACT_Y0) && (vn < ACT_Y0 + ACT_H);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync      <= 1'b1;
            pixel_req <= 1'b0;
            pixel     <= 1'b0;
        end else begin
            sync      <= sync_d;
            pixel_req <= req_d;
            pixel     <= pixel_req & pixel_in;
        end
    end

`ifdef VBS_FRAME_IRQ_EN
    localparam logic [VW-1:0] TRIG_V = VW'(ACT_Y0 + ACT_H);

    logic irq_unused;
    assign irq_unused = line_end;

    // A new trigger takes priority over a coincident acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_irq <= 1'b0;
        end else if (h_pos == '0 && v_pos == TRIG_V) begin
            frame_irq <= 1'b1;
        end else if (irq_ack) begin
            frame_irq <= 1'b0;
        end
    end
`else
    logic irq_unused;
    assign irq_unused = irq_ack ^ line_end;
    assign frame_irq  = 1'b0;
`endif

endmodule
